// File: rtl/alu_sequencer.sv
// Command-driven controller for a 16-bit zx/nx/zy/ny/f/no ALU.
// It accepts one op per command handshake and drives the ALU operands and control bits.
// It captures the result and flags and returns them on a response handshake.
// MUL is a WIDTH-cycle shift-and-add that routes each partial sum through the ALU adder.
module alu_sequencer #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zr,
    output logic             rsp_ng,
    output logic             rsp_err,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [5:0] CTL_ADD = 6'b000010;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zr_q, rsp_ng_q, rsp_err_q;

    logic             op_legal;
    logic [5:0]       op_ctl;
    logic [WIDTH-1:0] acc_next;
    logic             mul_last;

    // Opcode to ALU control decode; MUL is not an EXEC op, so it decodes as illegal here.
    always_comb begin
        op_legal = 1'b1;
        op_ctl   = 6'b000000;
        case (op_q)
            4'd0:    op_ctl = 6'b101010;
            4'd1:    op_ctl = 6'b111111;
            4'd2:    op_ctl = 6'b111010;
            4'd3:    op_ctl = 6'b001100;
            4'd4:    op_ctl = 6'b110000;
            4'd5:    op_ctl = 6'b001101;
            4'd6:    op_ctl = 6'b001111;
            4'd7:    op_ctl = 6'b011111;
            4'd8:    op_ctl = 6'b000010;
            4'd9:    op_ctl = 6'b010011;
            4'd10:   op_ctl = 6'b000111;
            4'd11:   op_ctl = 6'b000000;
            4'd12:   op_ctl = 6'b010101;
            default: op_legal = 1'b0;
        endcase
    end

    // Multiply step: the ALU computes acc + mcand, kept only when the multiplier LSB is set.
    always_comb begin
        acc_next = mplier_q[0] ? alu_out : acc_q;
        mul_last = (count_q == CW'(WIDTH - 1));
    end

    // Next-state and ALU/handshake outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_x     = '0;
        alu_y     = '0;
        alu_ctl   = 6'b000000;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = (MUL_EN && cmd_op == OP_MUL) ? StMul : StExec;
                end
            end
            StExec: begin
                alu_x   = a_q;
                alu_y   = b_q;
                alu_ctl = op_legal ? op_ctl : 6'b000000;
                state_d = StResp;
            end
            StMul: begin
                alu_x   = acc_q;
                alu_y   = mcand_q;
                alu_ctl = CTL_ADD;
                if (mul_last) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, multiply datapath and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            count_q    <= '0;
            rsp_data_q <= '0;
            rsp_zr_q   <= 1'b0;
            rsp_ng_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        a_q       <= cmd_a;
                        b_q       <= cmd_b;
                        acc_q     <= '0;
                        mcand_q   <= cmd_a;
                        mplier_q  <= cmd_b;
                        count_q   <= '0;
                        rsp_err_q <= 1'b0;
                    end
                end
                StExec: begin
                    if (op_legal) begin
                        rsp_data_q <= alu_out;
                        rsp_zr_q   <= alu_zr;
                        rsp_ng_q   <= alu_ng;
                        rsp_err_q  <= 1'b0;
                    end else begin
                        rsp_data_q <= '0;
                        rsp_zr_q   <= 1'b1;
                        rsp_ng_q   <= 1'b0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                StMul: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (mul_last) begin
                        // Flags come from the truncated product, not from the last ALU pass.
                        rsp_data_q <= acc_next;
                        rsp_zr_q   <= (acc_next == '0);
                        rsp_ng_q   <= acc_next[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_zr   = rsp_zr_q;
    assign rsp_ng   = rsp_ng_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a combinational ALU model closes the loop.
// Results are predicted by plain arithmetic on the opcode meaning.
module tb_alu_sequencer;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [3:0]    cmd_op;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [W-1:0]  alu_x, alu_y, alu_out;
    logic [5:0]    alu_ctl;
    logic          alu_zr, alu_ng;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_zr, rsp_ng, rsp_err, busy;

    int checks = 0;
    int failures = 0;

    alu_sequencer #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Combinational ALU driven by the sequencer's control bits {zx,nx,zy,ny,f,no}.
    logic [W-1:0] ax, ay, af;
    always_comb begin
        ax = alu_ctl[5] ? '0 : alu_x;
        ax = alu_ctl[4] ? ~ax : ax;
        ay = alu_ctl[3] ? '0 : alu_y;
        ay = alu_ctl[2] ? ~ay : ay;
        af = alu_ctl[1] ? (ax + ay) : (ax & ay);
        alu_out = alu_ctl[0] ? ~af : af;
        alu_zr = (alu_out == '0);
        alu_ng = alu_out[W-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference result {err, data} from the opcode's arithmetic meaning.
    function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [2*W-1:0] p;
        case (op)
            4'd0:  r = 0;
            4'd1:  r = 1;
            4'd2:  r = -1;
            4'd3:  r = a;
            4'd4:  r = b;
            4'd5:  r = ~a;
            4'd6:  r = -a;
            4'd7:  r = a + 1;
            4'd8:  r = a + b;
            4'd9:  r = a - b;
            4'd10: r = b - a;
            4'd11: r = a & b;
            4'd12: r = a | b;
            4'd13: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0];
            end
            default: return {1'b1, {W{1'b0}}};
        endcase
        return {1'b0, r};
    endfunction

    // Issue one command, wait for its response, optionally stall the consumer, then retire it.
    // Latency counts clock edges from the one that takes the command.
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        logic [W:0]   m;
        logic [W-1:0] held;
        int           edges;
        int           exp_lat;
        m = model(op, a, b);
        exp_lat = (op == 4'd13) ? W + 1 : 2;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = W'($urandom); cmd_b = W'($urandom);
        edges = 1;
        check("busy_after_accept", busy, 1);
        while (!rsp_valid && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, exp_lat);
        check("rsp_data", rsp_data, m[W-1:0]);
        check("rsp_zr", rsp_zr, (m[W-1:0] == '0));
        check("rsp_ng", rsp_ng, m[W-1]);
        check("rsp_err", rsp_err, m[W]);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 16'h0001; cmd_b = 16'h0001;
            end else begin
                cmd_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, held);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("retire_valid", rsp_valid, 0);
        check("retire_idle", busy, 0);
        check("retire_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [3:0] op;
        logic [W-1:0] a, b;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        #12;
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_flags", {rsp_zr, rsp_ng, rsp_err}, 0);
        check("reset_alu", {alu_x, alu_y, alu_ctl}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(4'd8, 16'h0005, 16'h0003, 0);
        run_cmd(4'd9, 16'h0003, 16'h0005, 0);
        run_cmd(4'd0, 16'h1111, 16'h2222, 0);
        run_cmd(4'd13, 16'h0007, 16'h0006, 0);
        run_cmd(4'd13, 16'h0100, 16'h0100, 0);
        run_cmd(4'd14, 16'h0001, 16'h0002, 0);
        run_cmd(4'd3, 16'h1234, 16'h0000, 0);
        run_cmd(4'd15, 16'hFFFF, 16'hFFFF, 0);
        run_cmd(4'd12, 16'h00F0, 16'h0F00, 5);

        // A command pulsed during the stall must not produce a second response.
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) seen++;
        end
        check("stall_cmd_dropped", seen, 0);

        // Reset in the middle of a multiply.
        cmd_valid = 1'b1; cmd_op = 4'd13; cmd_a = 16'h0007; cmd_b = 16'h0006;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_mul_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_cmd_ready", cmd_ready, 1);
        check("async_busy", busy, 0);
        check("async_rsp", {rsp_valid, rsp_data, rsp_zr, rsp_ng, rsp_err}, 0);
        check("async_alu", {alu_x, alu_y, alu_ctl}, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
        run_cmd(4'd8, 16'h0100, 16'h0023, 0);

        // Randomized ops, biased towards small and all-ones operands for zero/sign corners.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin a = W'($urandom_range(0, 3)); b = W'($urandom_range(0, 3)); end
                1: begin a = 16'hFFFF; b = W'($urandom); end
                default: begin a = W'($urandom); b = W'($urandom); end
            endcase
            run_cmd(op, a, b, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
